// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, drives the synchronous ROM/RAM port, and hands
// each fetched word to decode over a valid/ready handshake, with interleaved stores and jumps.
module fetch_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  halt_i,
    input  logic                  jump_i,
    input  logic [ADDR_WIDTH-1:0] jump_target_i,
    input  logic                  store_req_i,
    input  logic [ADDR_WIDTH-1:0] store_addr_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    output logic                  store_ack_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o
);
    // instr_valid_o/instr_ready_i: a word transfers on any rising edge where both
    // are high; while valid is high and ready low, instr_o and instr_pc_o stay stable.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CAPTURE = 3'd2,
        HOLD    = 3'd3,
        STORE   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] jump_tgt_q, jump_tgt_d;
    logic                  jump_pend_q, jump_pend_d;
    logic                  resume_q, resume_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  store_ack_q, store_ack_d;
    logic                  instr_valid_q, instr_valid_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;

    logic [ADDR_WIDTH-1:0] jump_word, store_word, pc_inc, tgt_now, pc_next;
    logic                  pend_now;
    logic                  unused_low_bits;

    assign jump_word       = {jump_target_i[ADDR_WIDTH-1:2], 2'b00};
    assign store_word      = {store_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign pc_inc          = pc_q + ADDR_WIDTH'(4);
    // A jump arriving in the same cycle as the PC update is the most recent one, so it wins.
    assign pend_now        = jump_pend_q | jump_i;
    assign tgt_now         = jump_i ? jump_word : jump_tgt_q;
    assign unused_low_bits = ^{jump_target_i[1:0], store_addr_i[1:0]};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        jump_tgt_d    = jump_tgt_q;
        jump_pend_d   = jump_pend_q;
        resume_d      = resume_q;
        mem_addr_d    = mem_addr_q;
        mem_we_d      = 1'b0;
        mem_wdata_d   = mem_wdata_q;
        store_ack_d   = 1'b0;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        pc_next       = pc_q;

        case (state_q)
            IDLE: begin
                if (store_req_i) begin
                    state_d     = STORE;
                    mem_addr_d  = store_word;
                    mem_wdata_d = store_data_i;
                    mem_we_d    = 1'b1;
                    store_ack_d = 1'b1;
                    resume_d    = 1'b0;
                end else if (start_i) begin
                    state_d    = FETCH;
                    mem_addr_d = pc_q;
                end
            end
            FETCH, CAPTURE: begin
                if (jump_i) begin
                    // The word in flight belongs to the old stream; refetch from the target.
                    state_d    = FETCH;
                    pc_d       = jump_word;
                    mem_addr_d = jump_word;
                end else if (state_q == FETCH) begin
                    state_d = CAPTURE;
                end else begin
                    state_d       = HOLD;
                    instr_d       = mem_rdata_i;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (jump_i) begin
                    jump_pend_d = 1'b1;
                    jump_tgt_d  = jump_word;
                end
                if (instr_ready_i) begin
                    instr_valid_d = 1'b0;
                    pc_next       = pend_now ? tgt_now : pc_inc;
                    pc_d          = pc_next;
                    jump_pend_d   = 1'b0;
                    if (store_req_i) begin
                        state_d     = STORE;
                        mem_addr_d  = store_word;
                        mem_wdata_d = store_data_i;
                        mem_we_d    = 1'b1;
                        store_ack_d = 1'b1;
                        resume_d    = !halt_i;
                    end else if (halt_i) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = FETCH;
                        mem_addr_d = pc_next;
                    end
                end
            end
            STORE: begin
                pc_next     = pend_now ? tgt_now : pc_q;
                pc_d        = pc_next;
                jump_pend_d = 1'b0;
                if (resume_q) begin
                    state_d    = FETCH;
                    mem_addr_d = pc_next;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            jump_tgt_q    <= '0;
            jump_pend_q   <= 1'b0;
            resume_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
            store_ack_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            jump_tgt_q    <= jump_tgt_d;
            jump_pend_q   <= jump_pend_d;
            resume_q      <= resume_d;
            mem_addr_q    <= mem_addr_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
            store_ack_q   <= store_ack_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    assign store_ack_o   = store_ack_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_we_o      = mem_we_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign instr_valid_o = instr_valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a synchronous memory model feeds the DUT,
// and a second instance with RESET_PC at the top of the address space covers PC wrap.
module tb_fetch_sequencer;
    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n, start, halt, jump, store_req, ready;
    logic [AW-1:0] jump_tgt, store_addr;
    logic [DW-1:0] store_data;
    logic          store_ack, mem_we, valid;
    logic [AW-1:0] mem_addr, instr_pc;
    logic [DW-1:0] mem_wdata, mem_rdata, instr;

    logic          w_rst_n, w_start;
    logic          w_store_ack, w_mem_we, w_valid;
    logic [AW-1:0] w_mem_addr, w_instr_pc;
    logic [DW-1:0] w_mem_wdata, w_mem_rdata, w_instr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .halt_i(halt),
        .jump_i(jump), .jump_target_i(jump_tgt),
        .store_req_i(store_req), .store_addr_i(store_addr), .store_data_i(store_data),
        .store_ack_o(store_ack), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .instr_valid_o(valid), .instr_ready_i(ready), .instr_o(instr), .instr_pc_o(instr_pc)
    );

    fetch_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(w_rst_n), .start_i(w_start), .halt_i(1'b0),
        .jump_i(1'b0), .jump_target_i('0),
        .store_req_i(1'b0), .store_addr_i('0), .store_data_i('0),
        .store_ack_o(w_store_ack), .mem_addr_o(w_mem_addr), .mem_we_o(w_mem_we),
        .mem_wdata_o(w_mem_wdata), .mem_rdata_i(w_mem_rdata),
        .instr_valid_o(w_valid), .instr_ready_i(1'b1), .instr_o(w_instr), .instr_pc_o(w_instr_pc)
    );

    // Unwritten locations read back as a recognisable function of their address.
    function automatic logic [DW-1:0] def_word(input logic [AW-1:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    logic [DW-1:0] mem_wr [logic [AW-1:0]];

    always @(posedge clk) begin
        if (mem_we) mem_wr[mem_addr] = mem_wdata;
        mem_rdata <= mem_wr.exists(mem_addr) ? mem_wr[mem_addr] : def_word(mem_addr);
    end

    always @(posedge clk) w_mem_rdata <= def_word(w_mem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 0; start = 0; halt = 0; jump = 0; jump_tgt = '0; ready = 0;
        store_req = 0; store_addr = '0; store_data = '0; w_rst_n = 0; w_start = 0;
        step(); step();
        chk("rst_state", dut.state_q, 0);
        chk("rst_pc", dut.pc_q, 32'h0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_ack", store_ack, 0);
        chk("rst_valid", valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_wdata", mem_wdata, 0);

        // Reset -> start, ready tied high
        rst_n = 1; start = 1; ready = 1;
        step(); start = 0;
        chk("fetch0_addr", mem_addr, 32'h0);
        chk("fetch0_valid", valid, 0);
        step();
        chk("cap0_valid", valid, 0);
        step();
        chk("hold0_valid", valid, 1);
        chk("hold0_pc", instr_pc, 32'h0);
        chk("hold0_instr", instr, 32'hC0DE_0000);
        step();
        chk("fetch1_addr", mem_addr, 32'h4);
        chk("fetch1_valid", valid, 0);
        step(); step();
        chk("hold1_valid", valid, 1);
        chk("hold1_pc", instr_pc, 32'h4);
        chk("hold1_instr", instr, 32'hC0DE_0004);
        step();
        chk("fetch2_addr", mem_addr, 32'h8);

        // Jump in CAPTURE while fetching 0x8
        step();
        jump = 1; jump_tgt = 32'h103;
        step(); jump = 0;
        chk("jmpcap_addr", mem_addr, 32'h100);
        chk("jmpcap_valid", valid, 0);
        step();
        chk("jmpcap_novalid", valid, 0);
        step();
        chk("jmpcap_hold_valid", valid, 1);
        chk("jmpcap_hold_pc", instr_pc, 32'h100);
        chk("jmpcap_hold_instr", instr, 32'hC0DE_0100);

        // Backpressure in HOLD with a store queued behind it
        ready = 0; store_req = 1; store_addr = 32'h23; store_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", valid, 1);
            chk("bp_pc", instr_pc, 32'h100);
            chk("bp_instr", instr, 32'hC0DE_0100);
            chk("bp_addr", mem_addr, 32'h100);
        end
        ready = 1;
        step();
        store_req = 0; jump = 1; jump_tgt = 32'h20;
        chk("st_we", mem_we, 1);
        chk("st_ack", store_ack, 1);
        chk("st_addr", mem_addr, 32'h20);
        chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("st_valid", valid, 0);
        step(); jump = 0;
        chk("post_st_we", mem_we, 0);
        chk("post_st_ack", store_ack, 0);
        chk("post_st_addr", mem_addr, 32'h20);
        step(); step();
        chk("raw_valid", valid, 1);
        chk("raw_pc", instr_pc, 32'h20);
        chk("raw_instr", instr, 32'hDEAD_BEEF);

        // Halt at the handshake, then restart from the advanced PC
        halt = 1;
        step(); halt = 0;
        chk("halt_state", dut.state_q, 0);
        chk("halt_valid", valid, 0);
        chk("halt_addr", mem_addr, 32'h20);
        repeat (3) step();
        chk("idle_addr", mem_addr, 32'h20);
        chk("idle_valid", valid, 0);
        chk("idle_we", mem_we, 0);
        start = 1;
        step(); start = 0;
        chk("restart_addr", mem_addr, 32'h24);
        step(); step();
        chk("restart_pc", instr_pc, 32'h24);

        // Two jumps while stalled in HOLD: the later target wins
        ready = 0; jump = 1; jump_tgt = 32'h40;
        step();
        jump_tgt = 32'h63;
        step(); jump = 0;
        chk("pend_valid", valid, 1);
        chk("pend_pc", instr_pc, 32'h24);
        chk("pend_addr", mem_addr, 32'h24);
        ready = 1;
        step();
        chk("pend_redirect_addr", mem_addr, 32'h60);
        chk("pend_redirect_valid", valid, 0);

        // Jump in FETCH
        jump = 1; jump_tgt = 32'h80;
        step(); jump = 0;
        chk("jf_addr", mem_addr, 32'h80);
        step(); step();
        chk("jf_valid", valid, 1);
        chk("jf_pc", instr_pc, 32'h80);
        chk("jf_instr", instr, 32'hC0DE_0080);

        // Store with halt at the handshake returns to IDLE
        halt = 1; store_req = 1; store_addr = 32'h30; store_data = 32'h1234_5678;
        step(); store_req = 0; halt = 0;
        chk("hs_ack", store_ack, 1);
        chk("hs_we", mem_we, 1);
        chk("hs_addr", mem_addr, 32'h30);
        chk("hs_wdata", mem_wdata, 32'h1234_5678);
        step();
        chk("hs_state", dut.state_q, 0);
        chk("hs_ack_off", store_ack, 0);
        chk("hs_pc", dut.pc_q, 32'h84);

        // Store beats start in IDLE, then reset lands in STORE
        store_req = 1; start = 1; store_addr = 32'h44; store_data = 32'hCAFE_F00D;
        step(); store_req = 0; start = 0;
        chk("idle_st_state", dut.state_q, 4);
        chk("idle_st_ack", store_ack, 1);
        chk("idle_st_addr", mem_addr, 32'h44);
        rst_n = 0;
        step();
        chk("mr_we", mem_we, 0);
        chk("mr_ack", store_ack, 0);
        chk("mr_state", dut.state_q, 0);
        chk("mr_pc", dut.pc_q, 32'h0);
        chk("mr_addr", mem_addr, 32'h0);
        rst_n = 1; start = 1;
        step(); start = 0;
        chk("mr_fetch_addr", mem_addr, 32'h0);

        // PC wrap from the top of the address space
        w_rst_n = 1; w_start = 1;
        step(); w_start = 0;
        chk("wrap_addr0", w_mem_addr, 32'hFFFF_FFFC);
        step(); step();
        chk("wrap_valid", w_valid, 1);
        chk("wrap_pc", w_instr_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", w_instr, 32'h3F21_FFFC);
        step();
        chk("wrap_addr1", w_mem_addr, 32'h0);
        chk("wrap_we", w_mem_we, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
